// File: rtl/sd_clock_gen.sv
// SD card clock generator: divides CLK into SD_CLK with a half-period of DIVIDER+1 cycles,
// applies divider changes only at rising edges, parks low on request and emits edge strobes.
module sd_clock_gen #(
    parameter int DIV_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [DIV_W-1:0] DIVIDER,
    input  logic             CLK_EN,
    output logic             SD_CLK,
    output logic             RISE_STB,
    output logic             FALL_STB,
    output logic             CLK_STOPPED
);

    localparam logic [0:0] ST_STOPPED = 1'b0;
    localparam logic [0:0] ST_RUN     = 1'b1;

    logic [0:0]       state_q,   state_d;
    logic [DIV_W-1:0] cnt_q,     cnt_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic             sd_clk_q,  sd_clk_d;
    logic             rise_q,    rise_d;
    logic             fall_q,    fall_d;
    logic             stopped_q, stopped_d;
    logic             term_cnt;

    // cnt only ever returns to zero through this compare, so all-ones dividers never overflow
    assign term_cnt = (cnt_q == div_act_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_act_d = div_act_q;
        sd_clk_d  = sd_clk_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        stopped_d = stopped_q;

        case (state_q)
            ST_RUN: begin
                if (!term_cnt) begin
                    cnt_d = cnt_q + DIV_W'(1);
                end else begin
                    cnt_d = '0;
                    if (sd_clk_q) begin
                        sd_clk_d = 1'b0;
                        fall_d   = 1'b1;
                    end else if (CLK_EN) begin
                        // the divider is only ever picked up at a rise, so both phases share it
                        sd_clk_d  = 1'b1;
                        rise_d    = 1'b1;
                        div_act_d = DIVIDER;
                    end else begin
                        stopped_d = 1'b1;
                        state_d   = ST_STOPPED;
                    end
                end
            end
            default: begin
                div_act_d = DIVIDER;
                cnt_d     = '0;
                sd_clk_d  = 1'b0;
                if (CLK_EN) begin
                    sd_clk_d  = 1'b1;
                    rise_d    = 1'b1;
                    stopped_d = 1'b0;
                    state_d   = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_STOPPED;
            cnt_q     <= '0;
            div_act_q <= '0;
            sd_clk_q  <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            stopped_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_act_q <= div_act_d;
            sd_clk_q  <= sd_clk_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            stopped_q <= stopped_d;
        end
    end

    assign SD_CLK      = sd_clk_q;
    assign RISE_STB    = rise_q;
    assign FALL_STB    = fall_q;
    assign CLK_STOPPED = stopped_q;

endmodule

// File: tb/tb_sd_clock_gen.sv
// Randomised bench for sd_clock_gen: a queue of expected SD_CLK samples is scheduled one full
// period at a time whenever a rise is due, and every cycle is compared against the DUT.
module tb_sd_clock_gen;

    localparam int DIV_W = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DIV_W-1:0] divider = '0;
    logic             clk_en = 1'b0;
    logic             sd_clk, rise_stb, fall_stb, clk_stopped;

    int n_vec = 0;
    int n_bad = 0;

    // each entry: {sd_clk, rise, fall} expected after one clock edge
    logic [2:0] exp_q[$];
    logic [2:0] exp_cur;
    logic       exp_stop;

    sd_clock_gen #(.DIV_W(DIV_W)) dut (
        .CLK(clk), .RST(rst), .DIVIDER(divider), .CLK_EN(clk_en),
        .SD_CLK(sd_clk), .RISE_STB(rise_stb), .FALL_STB(fall_stb), .CLK_STOPPED(clk_stopped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_outputs();
        chk("sd_clk",  sd_clk,      exp_cur[2]);
        chk("rise",    rise_stb,    exp_cur[1]);
        chk("fall",    fall_stb,    exp_cur[0]);
        chk("stopped", clk_stopped, exp_stop);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_cur  = 3'b000;
        exp_stop = 1'b1;
    endtask

    // apply inputs, clock once, advance the reference and compare
    task automatic step(input logic en, input logic [DIV_W-1:0] div);
        clk_en  = en;
        divider = div;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0 && en) begin
            for (int i = 0; i <= int'(div); i++) exp_q.push_back({1'b1, i == 0, 1'b0});
            for (int i = 0; i <= int'(div); i++) exp_q.push_back({1'b0, 1'b0, i == 0});
        end
        if (exp_q.size() != 0) begin
            exp_cur  = exp_q.pop_front();
            exp_stop = 1'b0;
        end else begin
            exp_cur  = 3'b000;
            exp_stop = 1'b1;
        end
        chk_outputs();
    endtask

    task automatic run_to_rise(input logic [DIV_W-1:0] div);
        int guard = 0;
        do begin
            step(1'b1, div);
            guard++;
        end while (!exp_cur[1] && guard < 3000);
        chk("rise_reached", exp_cur[1], 1'b1);
    endtask

    initial begin
        logic en_r;
        logic [DIV_W-1:0] div_r;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_outputs();
        rst = 1'b0;

        // idle while disabled, then DIVIDER=2 start-up: 3 high / 3 low
        repeat (3) step(1'b0, 10'd2);
        repeat (20) step(1'b1, 10'd2);

        // divide-by-two
        repeat (12) step(1'b1, 10'd0);

        // divider change from 3 to 1 in the second high cycle
        run_to_rise(10'd3);
        repeat (20) step(1'b1, 10'd1);
        run_to_rise(10'd3);
        repeat (20) step(1'b1, 10'd1);

        // stop request in the first high cycle, then restart
        run_to_rise(10'd4);
        repeat (16) step(1'b0, 10'd4);
        repeat (12) step(1'b1, 10'd4);

        // drop and reassert before the low phase terminal count
        run_to_rise(10'd4);
        repeat (7) step(1'b0, 10'd4);
        repeat (12) step(1'b1, 10'd4);

        // random enable and divider traffic
        en_r  = 1'b1;
        div_r = 10'd2;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) en_r = ~en_r;
            if ($urandom_range(0, 9) == 0) div_r = DIV_W'($urandom_range(0, 6));
            step(en_r, div_r);
        end

        // full-scale divider and asynchronous reset mid-phase
        repeat (30) step(1'b0, 10'd1023);
        repeat (1500) step(1'b1, 10'd1023);
        #3 rst = 1'b1;
        #1;
        model_reset();
        chk_outputs();
        @(posedge clk);
        #1;
        chk_outputs();
        rst = 1'b0;
        repeat (10) step(1'b1, 10'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sd_clock_gen.md
# sd_clock_gen

Parametrised SD card clock generator and successor to the fixed 8-bit divider. It derives SD_CLK from the system clock CLK using a DIV_W-bit half-period divider. A new divider value takes effect only at an SD_CLK period boundary, so no runt pulses occur. The block also parks SD_CLK low on request and emits one-cycle rise/fall strobes so the command and data paths can launch and sample on SD_CLK edges in the CLK domain.

## Interface
Parameters:
- DIV_W, 8, width of DIVIDER and of the internal counter.

Ports:
- CLK  input  1  system clock; all logic is on posedge CLK.
- RST  input  1  reset, asynchronous, active-high.
- DIVIDER  input  DIV_W  half-period select; each SD_CLK phase lasts DIVIDER+1 CLK cycles.
- CLK_EN  input  1  1 = run SD_CLK, 0 = park SD_CLK low at the next safe point.
- SD_CLK  output  1  generated SD clock, driven directly from a register.
- RISE_STB  output  1  high for exactly the first CLK cycle of each SD_CLK high phase.
- FALL_STB  output  1  high for exactly the first CLK cycle of each SD_CLK low phase.
- CLK_STOPPED  output  1  high while SD_CLK is parked low.

## Operation
- Internal state:
  - cnt (DIV_W bits).
  - div_act (DIV_W bits), the latched divider.
  - FSM state, one of STOPPED or RUN.
- Reset values: SD_CLK=0, RISE_STB=0, FALL_STB=0, CLK_STOPPED=1, cnt=0, div_act=0, state=STOPPED.
- STOPPED, every cycle: div_act<=DIVIDER, cnt<=0, SD_CLK stays 0.
- STOPPED with CLK_EN=1:
  - SD_CLK<=1, RISE_STB<=1, CLK_STOPPED<=0.
  - div_act<=DIVIDER sampled in the same cycle.
  - State goes to RUN.
- RUN, cnt != div_act: cnt<=cnt+1 and SD_CLK holds.
- RUN, cnt == div_act: cnt<=0, then:
  - If SD_CLK=1: SD_CLK<=0, FALL_STB<=1.
  - If SD_CLK=0 and CLK_EN=1: SD_CLK<=1, RISE_STB<=1, div_act<=DIVIDER.
  - If SD_CLK=0 and CLK_EN=0: SD_CLK stays 0, CLK_STOPPED<=1, state goes to STOPPED. No rise occurs.
- Divider latching:
  - div_act is loaded only on a rising SD_CLK transition or while STOPPED.
  - DIVIDER changes during a phase have no effect until the next rise.
  - The high phase and the following low phase always use the same div_act.
- CLK_EN=0 never truncates a phase. A high phase always completes, and the following low phase always completes its full div_act+1 cycles before the clock parks.
- CLK_EN reasserted during the final low phase, before its terminal count, means that phase ends with a normal rise and no stop.
- DIVIDER=0 gives SD_CLK = CLK/2 (1 cycle high, 1 cycle low). Strobes then alternate every cycle.
- DIVIDER all-ones gives a phase length of 2^DIV_W cycles. cnt wraps only via the terminal compare, never by overflow.
- RISE_STB and FALL_STB are never high in the same cycle. Each is zero in every cycle where it is not set above.

## Timing
- All outputs are registered. The latency from CLK_EN=1 sampled in STOPPED to SD_CLK=1 is 1 CLK cycle.
- Period in RUN = 2*(div_act+1) CLK cycles, duty 50%.
- RISE_STB/FALL_STB coincide with the first cycle of the new SD_CLK level, not the cycle before.
- The stop-request latency is worst case (div_act+1) high cycles plus (div_act+1) low cycles, after which CLK_STOPPED=1.
- CLK_STOPPED rises in the same cycle the low phase would have ended. It falls in the same cycle SD_CLK rises.
- RST asserted mid-phase forces all reset values immediately. There is no glitch-free requirement on reset.
- CLK_EN and DIVIDER are synchronous to CLK. No internal synchronisers.

## Test plan
- Reset release, DIVIDER=2, CLK_EN=1 -> SD_CLK=1 one cycle later with RISE_STB. Then SD_CLK runs 3 cycles high / 3 cycles low. FALL_STB is in the 4th cycle and RISE_STB in the 7th, then repeating.
- DIVIDER=0 -> SD_CLK toggles every cycle. RISE_STB and FALL_STB alternate, never coincident.
- Running at DIVIDER=3, change to 1 in the second cycle of a high phase -> the current high and low phases stay 4 cycles each. After the next rise, phases are 2 cycles each with no runt pulse.
- DIVIDER=4, drop CLK_EN in the first high cycle:
  - The high phase lasts 5 cycles and the low phase 5 cycles.
  - CLK_STOPPED=1 and SD_CLK stays 0 with no RISE_STB.
  - Reassert CLK_EN, and SD_CLK=1 follows 1 cycle later.
- CLK_EN drop then reassert before the low-phase terminal count -> normal rise on schedule, and CLK_STOPPED never asserts.
- DIV_W=10, DIVIDER=1023 -> phase length 1024 cycles. Assert RST mid-phase -> SD_CLK=0 and CLK_STOPPED=1 asynchronously.
